ahblite_dma_master: RTL and testbench

- Single-channel AHB-Lite initiator (bus master) that copies a block of 32-bit words from a source address to a destination address.
- Pairs with the AHB-Lite memory responders on the bus, such as the block-RAM slave, and sits on a spare master port of the bus matrix.
- Software or a control FSM loads source, destination and length, then pulses start.
- The engine performs non-pipelined SINGLE word transfers, a read then a write per word, and reports done or error.

---
 rtl/ahblite_dma_master.sv | 184 ++++++++++++++++++
 tb/tb_ahblite_dma_master.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahblite_dma_master.sv
// Single-channel AHB-Lite DMA initiator: copies a block of 32-bit words, one
// non-pipelined SINGLE read followed by one SINGLE write per word.
module ahblite_dma_master #(
  parameter int LEN_WIDTH = 16
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic                 start,
  input  logic [31:0]          src_addr,
  input  logic [31:0]          dst_addr,
  input  logic [LEN_WIDTH-1:0] length,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [31:0]          HADDR,
  output logic [1:0]           HTRANS,
  output logic                 HWRITE,
  output logic [2:0]           HSIZE,
  output logic [2:0]           HBURST,
  output logic [3:0]           HPROT,
  output logic                 HMASTLOCK,
  output logic [31:0]          HWDATA,
  input  logic [31:0]          HRDATA,
  input  logic                 HREADY,
  input  logic                 HRESP,
  output logic [2:0]           fsm_state
);

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    RD_D = 3'd2,
    WR_A = 3'd3,
    WR_D = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [31:0]          src_q, src_d;
  logic [31:0]          dst_q, dst_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
  logic [31:0]          buf_q, buf_d;
  logic [31:0]          haddr_q, haddr_d;
  logic [1:0]           htrans_q, htrans_d;
  logic                 hwrite_q, hwrite_d;
  logic [31:0]          hwdata_q, hwdata_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;

  assign HADDR     = haddr_q;
  assign HTRANS    = htrans_q;
  assign HWRITE    = hwrite_q;
  assign HWDATA    = hwdata_q;
  assign HSIZE     = 3'b010;
  assign HBURST    = 3'b000;
  assign HPROT     = 4'b0011;
  assign HMASTLOCK = 1'b0;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign fsm_state = state_q;

  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    cnt_d    = cnt_q;
    buf_d    = buf_q;
    haddr_d  = haddr_q;
    htrans_d = htrans_q;
    hwrite_d = hwrite_q;
    hwdata_d = hwdata_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    error_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (length != '0) begin
            src_d    = {src_addr[31:2], 2'b00};
            dst_d    = {dst_addr[31:2], 2'b00};
            cnt_d    = length;
            htrans_d = TRANS_NONSEQ;
            haddr_d  = {src_addr[31:2], 2'b00};
            hwrite_d = 1'b0;
            busy_d   = 1'b1;
            state_d  = RD_A;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RD_A: begin
        if (HREADY) begin
          htrans_d = TRANS_IDLE;
          state_d  = RD_D;
        end
      end
      RD_D: begin
        // Only the HREADY=1 cycle of a response counts; an ERROR's first cycle is just waited on.
        if (HREADY) begin
          if (HRESP) begin
            error_d = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            buf_d    = HRDATA;
            htrans_d = TRANS_NONSEQ;
            haddr_d  = dst_q;
            hwrite_d = 1'b1;
            state_d  = WR_A;
          end
        end
      end
      WR_A: begin
        if (HREADY) begin
          htrans_d = TRANS_IDLE;
          hwdata_d = buf_q;
          state_d  = WR_D;
        end
      end
      WR_D: begin
        if (HREADY) begin
          if (HRESP) begin
            error_d  = 1'b1;
            busy_d   = 1'b0;
            hwrite_d = 1'b0;
            state_d  = IDLE;
          end else begin
            src_d = src_q + 32'd4;
            dst_d = dst_q + 32'd4;
            cnt_d = cnt_q - LEN_WIDTH'(1);
            if (cnt_q == LEN_WIDTH'(1)) begin
              done_d   = 1'b1;
              busy_d   = 1'b0;
              hwrite_d = 1'b0;
              state_d  = IDLE;
            end else begin
              htrans_d = TRANS_NONSEQ;
              haddr_d  = src_q + 32'd4;
              hwrite_d = 1'b0;
              state_d  = RD_A;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      cnt_q    <= '0;
      buf_q    <= '0;
      haddr_q  <= '0;
      htrans_q <= TRANS_IDLE;
      hwrite_q <= 1'b0;
      hwdata_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      cnt_q    <= cnt_d;
      buf_q    <= buf_d;
      haddr_q  <= haddr_d;
      htrans_q <= htrans_d;
      hwrite_q <= hwrite_d;
      hwdata_q <= hwdata_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      error_q  <= error_d;
    end
  end

endmodule

// File: tb/tb_ahblite_dma_master.sv
// Bench for ahblite_dma_master: a behavioural AHB-Lite memory slave with wait
// states and ERROR injection, plus a copy-level reference model feeding a scoreboard.
module tb_ahblite_dma_master;

  localparam logic [1:0] K_RD   = 2'd0;
  localparam logic [1:0] K_WR   = 2'd1;
  localparam logic [1:0] K_DONE = 2'd2;
  localparam logic [1:0] K_ERR  = 2'd3;

  // clock / reset
  logic HCLK = 1'b0;
  logic HRESETn;
  always #5 HCLK = ~HCLK;

  logic        start;
  logic [31:0] src_addr, dst_addr;
  logic [15:0] length;
  logic        busy, done, error;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE, HMASTLOCK, HREADY, HRESP;
  logic [2:0]  HSIZE, HBURST, fsm_state;
  logic [3:0]  HPROT;

  ahblite_dma_master #(.LEN_WIDTH(16)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .src_addr(src_addr),
    .dst_addr(dst_addr), .length(length), .busy(busy), .done(done), .error(error),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HREADY(HREADY), .HRESP(HRESP), .fsm_state(fsm_state)
  );

  // scoreboard
  logic [65:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic observe(input logic [65:0] ev);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got %h expected none", ev);
    end else begin
      check("bus_event", ev, exp_q.pop_front());
    end
  endtask

  // memories: DUT-facing slave memory and the reference model's own view
  logic [31:0] mem[logic [31:0]];
  logic [31:0] ref_mem[logic [31:0]];

  function automatic logic [31:0] seed(input logic [31:0] a);
    return a ^ 32'h5A5A_0000 ^ {a[15:0], 16'h0};
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : seed(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : seed(a);
  endfunction

  // reference model: the complete event sequence for one copy request
  task automatic model(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l,
                       input int ek, input int ei);
    logic [31:0] sa, da, a, v;
    sa = {s[31:2], 2'b00};
    da = {d[31:2], 2'b00};
    for (int i = 0; i < int'(l); i++) begin
      a = sa + 32'(4 * i);
      if (ek == 1 && i == ei) begin
        exp_q.push_back({K_ERR, 64'h0});
        return;
      end
      exp_q.push_back({K_RD, a, 32'h0});
      v = ref_rd(a);
      if (ek == 2 && i == ei) begin
        exp_q.push_back({K_ERR, 64'h0});
        return;
      end
      exp_q.push_back({K_WR, da + 32'(4 * i), v});
      ref_mem[da + 32'(4 * i)] = v;
    end
    exp_q.push_back({K_DONE, 64'h0});
  endtask

  // slave configuration and state
  int          cfg_waits, cfg_err_kind, cfg_err_idx;
  int          rd_cnt, wr_cnt;
  logic        dp_active, dp_write, dp_first;
  logic [31:0] dp_addr, dp_wdata;
  int          dp_waits, dp_err;
  logic        prev_addr_valid, prev_write, prev_hready;
  logic [31:0] prev_addr;

  // slave + monitor: decides this cycle's response, observes completed transfers
  always @(negedge HCLK) begin
    if (!HRESETn) begin
      dp_active = 1'b0;
      prev_addr_valid = 1'b0;
      prev_hready = 1'b1;
      HREADY = 1'b1;
      HRESP = 1'b0;
    end else begin
      if (dp_active && prev_hready) dp_active = 1'b0;
      if (prev_addr_valid && prev_hready) begin
        dp_active = 1'b1;
        dp_write = prev_write;
        dp_addr = prev_addr;
        dp_waits = cfg_waits;
        dp_first = 1'b1;
        dp_err = 0;
        if (prev_write) begin
          if (cfg_err_kind == 2 && wr_cnt == cfg_err_idx) dp_err = 2;
          wr_cnt++;
        end else begin
          if (cfg_err_kind == 1 && rd_cnt == cfg_err_idx) dp_err = 2;
          rd_cnt++;
        end
      end
      HREADY = 1'b1;
      HRESP = 1'b0;
      if (dp_active) begin
        check("haddr_hold", HADDR, dp_addr);
        if (dp_write) begin
          if (dp_first) dp_wdata = HWDATA;
          else check("hwdata_hold", HWDATA, dp_wdata);
        end
        dp_first = 1'b0;
        if (dp_waits > 0) begin
          HREADY = 1'b0;
          dp_waits--;
        end else if (dp_err == 2) begin
          HREADY = 1'b0;
          HRESP = 1'b1;
          dp_err = 1;
        end else if (dp_err == 1) begin
          HRESP = 1'b1;
        end else if (dp_write) begin
          mem[dp_addr] = HWDATA;
          observe({K_WR, dp_addr, HWDATA});
        end else begin
          HRDATA = mem_rd(dp_addr);
          observe({K_RD, dp_addr, 32'h0});
        end
      end
      if (done) observe({K_DONE, 64'h0});
      if (error) observe({K_ERR, 64'h0});
      if (done && error) check("done_error_exclusive", {done, error}, 2'b00);
      if (dp_active || HTRANS == 2'b10) check("busy_during_xfer", busy, 1'b1);
      prev_addr_valid = (HTRANS == 2'b10);
      prev_write = HWRITE;
      prev_addr = HADDR;
      prev_hready = HREADY;
    end
  end

  // driver tasks
  task automatic step();
    @(negedge HCLK);
    #1;
  endtask

  task automatic pulse_start(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
    step();
    src_addr = s;
    dst_addr = d;
    length = l;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic issue_copy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l,
                            input int waits, input int ek, input int ei);
    cfg_waits = waits;
    cfg_err_kind = ek;
    cfg_err_idx = ei;
    rd_cnt = 0;
    wr_cnt = 0;
    model(s, d, l, ek, ei);
    pulse_start(s, d, l);
  endtask

  task automatic wait_quiet(input string name);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      step();
      if (exp_q.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, "_complete"}, ok, 1'b1);
    step();
    step();
  endtask

  initial begin
    logic [31:0] s, d;
    logic [15:0] l;
    int w, ek, ei;
    logic ok;

    HRESETn = 1'b0;
    start = 1'b0;
    src_addr = '0;
    dst_addr = '0;
    length = '0;
    HREADY = 1'b1;
    HRESP = 1'b0;
    HRDATA = '0;
    cfg_waits = 0;
    cfg_err_kind = 0;
    cfg_err_idx = 0;
    rd_cnt = 0;
    wr_cnt = 0;
    repeat (3) step();
    check("rst_htrans", HTRANS, 2'b00);
    check("rst_haddr", HADDR, 32'h0);
    check("rst_hwrite", HWRITE, 1'b0);
    check("rst_hwdata", HWDATA, 32'h0);
    check("rst_flags", {busy, done, error}, 3'b000);
    check("rst_state", fsm_state, 3'd0);
    check("const_ctrl", {HSIZE, HBURST, HPROT, HMASTLOCK}, {3'b010, 3'b000, 4'b0011, 1'b0});
    HRESETn = 1'b1;
    step();

    // zero-wait single word, cycle-exact
    mem[32'h100] = 32'hDEADBEEF;
    ref_mem[32'h100] = 32'hDEADBEEF;
    issue_copy(32'h100, 32'h200, 16'd1, 0, 0, 0);
    check("c1_rd_addr", {HTRANS, HWRITE, HADDR, busy}, {2'b10, 1'b0, 32'h100, 1'b1});
    step();
    check("c2_idle", HTRANS, 2'b00);
    step();
    check("c3_wr_addr", {HTRANS, HWRITE, HADDR}, {2'b10, 1'b1, 32'h200});
    step();
    check("c4_hwdata", HWDATA, 32'hDEADBEEF);
    step();
    check("c5_done", {done, busy}, 2'b10);
    wait_quiet("single");
    check("mem_200", mem_rd(32'h200), 32'hDEADBEEF);

    // three words with two wait states per data phase
    issue_copy(32'h100, 32'h200, 16'd3, 2, 0, 0);
    wait_quiet("waits3");

    // zero-length request
    issue_copy(32'h300, 32'h340, 16'd0, 0, 0, 0);
    check("len0_done", {done, busy, HTRANS}, {1'b1, 1'b0, 2'b00});
    step();
    check("len0_after", {done, busy, HTRANS}, {1'b0, 1'b0, 2'b00});
    wait_quiet("len0");

    // ERROR on the second read of a four-word copy
    issue_copy(32'h1100, 32'h1200, 16'd4, 1, 1, 1);
    wait_quiet("rd_error");
    check("err_state_idle", fsm_state, 3'd0);
    check("err_htrans_idle", HTRANS, 2'b00);

    // restart attempt while busy must be ignored
    issue_copy(32'h400, 32'h500, 16'd2, 1, 0, 0);
    step();
    check("busy_before_restart", busy, 1'b1);
    src_addr = 32'h700;
    dst_addr = 32'h780;
    length = 16'd5;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_quiet("restart_ignored");

    // address wrap past 0xFFFFFFFC with unaligned request bits
    issue_copy(32'hFFFF_FFFE, 32'h0000_0303, 16'd2, 0, 0, 0);
    wait_quiet("wrap");

    // randomized copies with random waits and occasional ERROR
    for (int n = 0; n < 10; n++) begin
      s = 32'h2000 + 32'(n * 32'h100) + 32'($urandom_range(0, 3));
      d = 32'h9000 + 32'(n * 32'h100) + 32'($urandom_range(0, 3));
      l = 16'($urandom_range(1, 6));
      w = $urandom_range(0, 3);
      ek = $urandom_range(0, 3);
      if (ek > 2) ek = 0;
      ei = $urandom_range(0, int'(l) - 1);
      issue_copy(s, d, l, w, ek, ei);
      wait_quiet("random");
    end

    // asynchronous reset while the write data phase is stalled
    issue_copy(32'h600, 32'h680, 16'd2, 3, 0, 0);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (fsm_state == 3'd4) begin
        ok = 1'b1;
        break;
      end
    end
    check("reach_wr_d", ok, 1'b1);
    HRESETn = 1'b0;
    #1;
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_htrans", HTRANS, 2'b00);
    check("rst_mid_hwdata", HWDATA, 32'h0);
    check("rst_mid_state", fsm_state, 3'd0);
    exp_q.delete();
    step();
    step();
    HRESETn = 1'b1;
    step();
    issue_copy(32'h800, 32'h880, 16'd1, 0, 0, 0);
    wait_quiet("after_reset");

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
